// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for the BCD HH:MM:SS reminder countdown timer.
//   master : drives tick/load/load_hh/load_mm/load_ss/start/stop/ack,
//            observes hh/mm/ss/running/alarm/expired/load_err
//   slave  : the timer itself (mirror image of master)
// All time values are two-digit BCD bytes {tens, units}.
interface bcd_countdown_timer_if;
    logic       tick;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       start;
    logic       stop;
    logic       ack;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       running;
    logic       alarm;
    logic       expired;
    logic       load_err;

    modport master (
        output tick, load, load_hh, load_mm, load_ss, start, stop, ack,
        input  hh, mm, ss, running, alarm, expired, load_err
    );

    modport slave (
        input  tick, load, load_hh, load_mm, load_ss, start, stop, ack,
        output hh, mm, ss, running, alarm, expired, load_err
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Six-digit BCD HH:MM:SS down-counter used as the reminder interval timer.
// A loaded interval counts down one second per 1 Hz tick; reaching 00:00:00
// raises a sticky alarm, and acknowledging it reloads the interval (resuming
// the countdown when AUTO_RESTART is set, otherwise parking in IDLE).
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : bcd_countdown_timer_if.slave
//            inputs  tick, load, load_hh/mm/ss, start, stop, ack
//            outputs hh/mm/ss (remaining time), running, alarm,
//                    expired (1-cycle), load_err (1-cycle); all registered
// Per-cycle priority: reset > load > ack > stop > start > tick.
module bcd_countdown_timer #(
    parameter logic [7:0] DEF_HH       = 8'h01,
    parameter logic [7:0] DEF_MM       = 8'h00,
    parameter logic [7:0] DEF_SS       = 8'h00,
    parameter bit         AUTO_RESTART = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic [23:0] DEF_COUNT = {DEF_HH, DEF_MM, DEF_SS};
    localparam logic [23:0] ZERO_TIME = 24'h00_00_00;
    localparam logic [23:0] ONE_SEC   = 24'h00_00_01;

    // A time is legal when every digit is decimal, minute/second tens are 0-5
    // and the hour byte is at most 23.
    function automatic logic bcd_time_valid(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ok = ok & (t[i*4 +: 4] <= 4'd9);
        end
        ok = ok & (t[7:4]   <= 4'd5);
        ok = ok & (t[15:12] <= 4'd5);
        ok = ok & (t[23:16] <= 8'h23);
        return ok;
    endfunction

    // Subtract one second with BCD ripple borrow. Digit order from LSB:
    // ss units, ss tens, mm units, mm tens, hh units, hh tens. A digit at 0
    // wraps to its maximum (5 for the seconds/minutes tens, 9 otherwise) and
    // passes the borrow on. Callers never pass 00:00:00.
    function automatic logic [23:0] bcd_time_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  wrap;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wrap = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = wrap;
                    borrow      = 1'b1;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [23:0] count_r, count_nxt_s;
    logic [23:0] shadow_r, shadow_nxt_s;
    logic        running_r, alarm_r, expired_r, load_err_r;
    logic        expired_nxt_s, load_err_nxt_s;
    logic [23:0] load_val_s;
    logic        load_ok_s;

    assign load_val_s = {bus.load_hh, bus.load_mm, bus.load_ss};
    assign load_ok_s  = bcd_time_valid(load_val_s);

    // Next-state, next-count and pulse generation in priority order.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        shadow_nxt_s   = shadow_r;
        expired_nxt_s  = 1'b0;
        load_err_nxt_s = 1'b0;
        if (bus.load) begin
            // A rejected load consumes the cycle without touching anything.
            if (load_ok_s) begin
                count_nxt_s  = load_val_s;
                shadow_nxt_s = load_val_s;
                state_nxt_s  = ST_IDLE;
            end else begin
                load_err_nxt_s = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && (count_r != ZERO_TIME)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_nxt_s = ST_IDLE;
                    end else if (bus.tick && (count_r == ONE_SEC)) begin
                        count_nxt_s   = ZERO_TIME;
                        state_nxt_s   = ST_ALARM;
                        expired_nxt_s = 1'b1;
                    end else if (bus.tick && (count_r != ZERO_TIME)) begin
                        count_nxt_s = bcd_time_dec(count_r);
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
                ST_ALARM: begin
                    if (bus.ack) begin
                        count_nxt_s = shadow_r;
                        state_nxt_s = AUTO_RESTART ? ST_RUN : ST_IDLE;
                    end else begin
                        count_nxt_s = ZERO_TIME;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe parked state.
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, interval and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= DEF_COUNT;
            shadow_r   <= DEF_COUNT;
            running_r  <= 1'b0;
            alarm_r    <= 1'b0;
            expired_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            shadow_r   <= shadow_nxt_s;
            running_r  <= (state_nxt_s == ST_RUN);
            alarm_r    <= (state_nxt_s == ST_ALARM);
            expired_r  <= expired_nxt_s;
            load_err_r <= load_err_nxt_s;
        end
    end

    assign bus.hh       = count_r[23:16];
    assign bus.mm       = count_r[15:8];
    assign bus.ss       = count_r[7:0];
    assign bus.running  = running_r;
    assign bus.alarm    = alarm_r;
    assign bus.expired  = expired_r;
    assign bus.load_err = load_err_r;

endmodule
